// File: rtl/multi_filter_control_unit_pkg.sv
// Shared definitions for the multi-filter convolution controller.
//   state_e        : controller state encoding (3-bit)
//   clamp_filters  : maps a requested filter count onto 1..max_f
package multi_filter_control_unit_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_START    = 3'd1,
        INIT          = 3'd2,
        READ_NEW_DATA = 3'd3,
        RUN           = 3'd4,
        WAIT_WR       = 3'd5,
        WRITE         = 3'd6
    } state_e;

    // A request of 0 means "one filter"; anything above max_f saturates.
    function automatic int unsigned clamp_filters(input int unsigned req,
                                                  input int unsigned max_f);
        int unsigned res;
        res = req;
        if (req == 0) begin
            res = 1;
        end else if (req > max_f) begin
            res = max_f;
        end
        return res;
    endfunction

endpackage

// File: rtl/mfcu_filter_counter.sv
// Wrap-around slot counter: counts 0..last_i on en_i, clr_i has priority.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en_i       : advance one slot
//   clr_i      : force back to slot 0
//   last_i     : highest slot before wrapping to 0
//   cnt_o      : current slot
module mfcu_filter_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == last_i) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_filter_control_unit.sv
// Convolution datapath controller: parameter load, IF fetch, MAC runs with
// per-filter interleaving over one shared IF window, and psum write-back.
// Strobes are decoded same-cycle from the state and datapath status.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   Start / ready, done       : host handshake
//   num_filters               : filters per IF window, latched in INIT
//   wait_data .. co_psum      : datapath status inputs
//   run_pipe .. wen_Psum      : pipeline / scratchpad strobes
//   ld_params .. done_psum    : setup / write-back strobes
//   filter_idx                : filter slot fed to the pipe this cycle
//   psum_mult                 : latched filter count (psum stride)
// Optional: MFCU_STALL_CNT_EN adds stall_cycles (stalled-cycle counter).
module multi_filter_control_unit
    import multi_filter_control_unit_pkg::*;
#(
    parameter int unsigned MAX_FILTERS = 4,
    parameter int unsigned FI_W        = $clog2(MAX_FILTERS),
    parameter int unsigned NF_W        = $clog2(MAX_FILTERS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [NF_W-1:0] num_filters,
    input  logic            wait_data,
    input  logic            at_end_data,
    input  logic            co_pipe,
    input  logic            valid_start_addr,
    input  logic            wr_psum_in,
    input  logic            co_psum,
    output logic            run_pipe,
    output logic            read_data,
    output logic            read_filter,
    output logic            clr_pipe,
    output logic            done_data,
    output logic            clr_addr,
    output logic            wen_Psum,
    output logic            ld_params,
    output logic            r_next_IF,
    output logic            r_next_Filter,
    output logic            ld_psum_addr,
    output logic            sel_psum_addr,
    output logic            clr_psum_addr,
    output logic            done_psum,
    output logic [FI_W-1:0] filter_idx,
    output logic [NF_W-1:0] psum_mult,
    output logic            ready,
`ifdef MFCU_STALL_CNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            done
);

    state_e          ps_q;
    state_e          ps_d;
    logic [NF_W-1:0] nf_q;
    logic [NF_W-1:0] nf_clamped;
    logic [FI_W-1:0] fidx;
    logic            fidx_en;
    logic            fidx_clr;
    logic            adv;

    assign nf_clamped = NF_W'(clamp_filters(32'(num_filters), MAX_FILTERS));
    assign adv        = !wait_data;

    // Slot counter walks 0..nf_q-1 on every advancing RUN cycle.
    mfcu_filter_counter #(.W(FI_W)) u_fidx (
        .clk    (clk),
        .rst    (rst),
        .en_i   (fidx_en),
        .clr_i  (fidx_clr),
        .last_i (FI_W'(nf_q - NF_W'(1))),
        .cnt_o  (fidx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= IDLE;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Filter count is only captured while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            nf_q <= NF_W'(1);
        end else if (ps_q == INIT) begin
            nf_q <= nf_clamped;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        ps_d          = ps_q;
        fidx_en       = 1'b0;
        fidx_clr      = 1'b1;
        run_pipe      = 1'b0;
        read_data     = 1'b0;
        read_filter   = 1'b0;
        clr_pipe      = 1'b0;
        done_data     = 1'b0;
        clr_addr      = 1'b0;
        wen_Psum      = 1'b0;
        ld_params     = 1'b0;
        r_next_IF     = 1'b0;
        r_next_Filter = 1'b0;
        ld_psum_addr  = 1'b0;
        sel_psum_addr = 1'b0;
        clr_psum_addr = 1'b0;
        done_psum     = 1'b0;
        ready         = 1'b0;
        done          = 1'b0;
        case (ps_q)
            IDLE: begin
                if (Start) ps_d = WAIT_START;
            end
            WAIT_START: begin
                if (!Start) ps_d = INIT;
            end
            INIT: begin
                ld_params = 1'b1;
                ready     = 1'b1;
                if (!wr_psum_in) begin
                    r_next_IF     = 1'b1;
                    r_next_Filter = 1'b1;
                    ld_psum_addr  = (nf_clamped > NF_W'(1));
                    sel_psum_addr = (nf_clamped > NF_W'(1));
                    ps_d          = READ_NEW_DATA;
                end
            end
            READ_NEW_DATA: begin
                if (!wait_data) ps_d = RUN;
            end
            RUN: begin
                wen_Psum    = adv;
                run_pipe    = adv;
                read_filter = adv;
                // One IF word is shared by every filter slot of the window.
                read_data   = adv && (fidx == '0);
                done_data   = at_end_data;
                clr_addr    = at_end_data;
                r_next_IF   = at_end_data && (nf_q == NF_W'(1));
                clr_pipe    = co_pipe && adv;
                if (at_end_data) begin
                    ps_d = WAIT_WR;
                end else if (!valid_start_addr && wait_data) begin
                    ps_d = READ_NEW_DATA;
                end
                fidx_en  = adv;
                fidx_clr = (ps_d != RUN);
            end
            WAIT_WR: begin
                clr_psum_addr = wr_psum_in;
                if (wr_psum_in) ps_d = WRITE;
            end
            WRITE: begin
                done_psum    = 1'b1;
                done         = 1'b1;
                ld_psum_addr = co_psum;
                if (co_psum) ps_d = INIT;
            end
            default: begin
                ps_d = IDLE;
            end
        endcase
    end

    assign filter_idx = fidx;
    assign psum_mult  = nf_q;

`ifdef MFCU_STALL_CNT_EN
    logic [31:0] stall_q;

    // Stalled cycles: waiting for a new window, or RUN held by wait_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (ps_q == INIT) begin
            stall_q <= '0;
        end else if (((ps_q == READ_NEW_DATA) || ((ps_q == RUN) && wait_data))
                     && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_multi_filter_control_unit.sv
// Self-checking bench for multi_filter_control_unit: directed steps from the
// feature list followed by a randomized run, all compared against a
// transaction-level reference (filter slot = advancing beats mod count).
module tb_multi_filter_control_unit;

    localparam int unsigned MAXF = 4;
    localparam int unsigned FI_W = 2;
    localparam int unsigned NF_W = 3;

    // Bit positions inside the packed output vector.
    localparam int B_LP = 20, B_RDY = 19, B_RIF = 18, B_RF = 17, B_LPA = 16;
    localparam int B_SPA = 15, B_CPA = 14, B_DPS = 13, B_DN = 12, B_RP = 11;
    localparam int B_RD = 10, B_RFL = 9, B_CP = 8, B_DD = 7, B_CA = 6, B_WP = 5;

    // Reference phases (bench's own labels).
    localparam int M_NONE = -1, M_IDLE = 0, M_ARM = 1, M_SETUP = 2;
    localparam int M_FETCH = 3, M_MAC = 4, M_WWAIT = 5, M_WB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, Start, wait_data, at_end_data, co_pipe;
    logic            valid_start_addr, wr_psum_in, co_psum;
    logic [NF_W-1:0] num_filters;
    logic            run_pipe, read_data, read_filter, clr_pipe, done_data;
    logic            clr_addr, wen_Psum, ld_params, r_next_IF, r_next_Filter;
    logic            ld_psum_addr, sel_psum_addr, clr_psum_addr, done_psum;
    logic            ready, done;
    logic [FI_W-1:0] filter_idx;
    logic [NF_W-1:0] psum_mult;
`ifdef MFCU_STALL_CNT_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     m_stall;
`endif

    multi_filter_control_unit #(.MAX_FILTERS(MAXF)) dut (
        .clk              (clk),
        .rst              (rst),
        .Start            (Start),
        .num_filters      (num_filters),
        .wait_data        (wait_data),
        .at_end_data      (at_end_data),
        .co_pipe          (co_pipe),
        .valid_start_addr (valid_start_addr),
        .wr_psum_in       (wr_psum_in),
        .co_psum          (co_psum),
        .run_pipe         (run_pipe),
        .read_data        (read_data),
        .read_filter      (read_filter),
        .clr_pipe         (clr_pipe),
        .done_data        (done_data),
        .clr_addr         (clr_addr),
        .wen_Psum         (wen_Psum),
        .ld_params        (ld_params),
        .r_next_IF        (r_next_IF),
        .r_next_Filter    (r_next_Filter),
        .ld_psum_addr     (ld_psum_addr),
        .sel_psum_addr    (sel_psum_addr),
        .clr_psum_addr    (clr_psum_addr),
        .done_psum        (done_psum),
        .filter_idx       (filter_idx),
        .psum_mult        (psum_mult),
        .ready            (ready),
`ifdef MFCU_STALL_CNT_EN
        .stall_cycles     (stall_cycles),
`endif
        .done             (done)
    );

    logic [20:0] obs, last_obs;
    assign obs = {ld_params, ready, r_next_IF, r_next_Filter, ld_psum_addr,
                  sel_psum_addr, clr_psum_addr, done_psum, done, run_pipe,
                  read_data, read_filter, clr_pipe, done_data, clr_addr,
                  wen_Psum, filter_idx, psum_mult};

    int n_cmp = 0;
    int n_err = 0;
    int mp    = M_NONE;
    int mn    = 1;
    int madv  = 0;

    function automatic int clampf(input int v);
        return (v == 0) ? 1 : ((v > int'(MAXF)) ? int'(MAXF) : v);
    endfunction

    // Expected outputs for the current phase and the inputs now applied.
    function automatic logic [20:0] expect_vec();
        logic [20:0] v;
        int          fi;
        logic        go;
        v  = '0;
        fi = (mp == M_MAC) ? (madv % mn) : 0;
        go = !wait_data;
        case (mp)
            M_SETUP: begin
                v[B_LP]  = 1'b1;
                v[B_RDY] = 1'b1;
                if (!wr_psum_in) begin
                    v[B_RIF] = 1'b1;
                    v[B_RF]  = 1'b1;
                    v[B_LPA] = (clampf(int'(num_filters)) > 1);
                    v[B_SPA] = (clampf(int'(num_filters)) > 1);
                end
            end
            M_MAC: begin
                v[B_WP]  = go;
                v[B_RP]  = go;
                v[B_RFL] = go;
                v[B_RD]  = go && (fi == 0);
                v[B_DD]  = at_end_data;
                v[B_CA]  = at_end_data;
                v[B_RIF] = at_end_data && (mn == 1);
                v[B_CP]  = co_pipe && go;
            end
            M_WWAIT: v[B_CPA] = wr_psum_in;
            M_WB: begin
                v[B_DPS] = 1'b1;
                v[B_DN]  = 1'b1;
                v[B_LPA] = co_psum;
            end
            default: ;
        endcase
        v[4:3] = 2'(fi);
        v[2:0] = 3'(mn);
        return v;
    endfunction

    // Advance the reference by one clock using the inputs seen at the edge.
    task automatic model_step();
        if (rst) begin
            mp = M_IDLE; mn = 1; madv = 0;
`ifdef MFCU_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
`ifdef MFCU_STALL_CNT_EN
            if (mp == M_SETUP) m_stall = 0;
            else if (((mp == M_FETCH) || (mp == M_MAC && wait_data)) && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
`endif
            case (mp)
                M_IDLE:  if (Start) mp = M_ARM;
                M_ARM:   if (!Start) mp = M_SETUP;
                M_SETUP: begin
                    mn = clampf(int'(num_filters));
                    if (!wr_psum_in) mp = M_FETCH;
                end
                M_FETCH: begin
                    madv = 0;
                    if (!wait_data) mp = M_MAC;
                end
                M_MAC: begin
                    if (!wait_data) madv = madv + 1;
                    if (at_end_data) mp = M_WWAIT;
                    else if (!valid_start_addr && wait_data) mp = M_FETCH;
                end
                M_WWAIT: if (wr_psum_in) mp = M_WB;
                M_WB:    if (co_psum) mp = M_SETUP;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, o, e);
        end
    endtask

    // One clock: compare outputs mid-cycle, then clock and step the reference.
    task automatic tick();
        logic [20:0] ev;
        #2;
        if (mp != M_NONE) begin
            ev = expect_vec();
            n_cmp++;
            assert (obs === ev) else begin
                n_err++;
                $error("FAIL outs t=%0t observed=%b expected=%b", $time, obs, ev);
            end
`ifdef MFCU_STALL_CNT_EN
            chk("stall", stall_cycles, m_stall);
`endif
        end
        last_obs = obs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    int cnt;

    initial begin
        rst = 1'b1; Start = 1'b1; num_filters = '0; wait_data = 1'b0;
        at_end_data = 1'b0; co_pipe = 1'b0; valid_start_addr = 1'b1;
        wr_psum_in = 1'b0; co_psum = 1'b0;
`ifdef MFCU_STALL_CNT_EN
        m_stall = 0;
`endif

        // Reset held three cycles with Start high.
        repeat (3) tick();
        chk("rst_strobes", 32'(last_obs[20:5]), 32'd0);
        chk("rst_mult", 32'(psum_mult), 32'd1);
        rst = 1'b0;

        // Single filter, no stalls, 8-beat window.
        tick();                     // IDLE -> WAIT_START
        Start = 1'b0; tick();       // WAIT_START -> INIT
        num_filters = 3'd1; tick(); // INIT
        chk("init_ldp", 32'(last_obs[B_LP]), 32'd1);
        chk("init1_lpa", 32'(last_obs[B_LPA]), 32'd0);
        tick();                     // READ_NEW_DATA -> RUN
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            at_end_data = (i == 7);
            tick();
            cnt += int'(last_obs[B_RD]);
            chk("nf1_fidx", 32'(last_obs[4:3]), 32'd0);
        end
        chk("nf1_reads", 32'(cnt), 32'd8);
        chk("nf1_rnext", 32'(last_obs[B_RIF]), 32'd1);
        at_end_data = 1'b0;

        // Write-back: co_psum on the fourth WRITE cycle.
        wr_psum_in = 1'b1; tick();
        chk("wb_clr", 32'(last_obs[B_CPA]), 32'd1);
        wr_psum_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            co_psum = (k == 3);
            tick();
            cnt += int'(last_obs[B_DN]);
            chk("wb_ld", 32'(last_obs[B_LPA]), 32'(k == 3));
        end
        chk("wb_done_cnt", 32'(cnt), 32'd4);
        co_psum = 1'b0;

        // Three filters, interleaved slots and a stall at slot 1.
        num_filters = 3'd3; tick();
        chk("nf3_lpa", 32'(last_obs[B_LPA]), 32'd1);
        chk("nf3_spa", 32'(last_obs[B_SPA]), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nf3_fidx", 32'(last_obs[4:3]), 32'(i % 3));
            chk("nf3_rd", 32'(last_obs[B_RD]), 32'(i % 3 == 0));
        end
        wait_data = 1'b1;
        repeat (2) begin
            tick();
            chk("hold_fidx", 32'(last_obs[4:3]), 32'd1);
            chk("hold_run", 32'(last_obs[B_RP]), 32'd0);
        end
        valid_start_addr = 1'b0; tick(); // RUN -> READ_NEW_DATA
        tick();
        chk("refetch_fidx", 32'(last_obs[4:3]), 32'd0);
        wait_data = 1'b0; valid_start_addr = 1'b1; tick();
        tick();
        chk("resume_fidx", 32'(last_obs[4:3]), 32'd0);
        at_end_data = 1'b1; co_pipe = 1'b1; tick();
        chk("end_clrpipe", 32'(last_obs[B_CP]), 32'd1);
        chk("end_done_data", 32'(last_obs[B_DD]), 32'd1);
        chk("end_rnext_nf3", 32'(last_obs[B_RIF]), 32'd0);
        at_end_data = 1'b0; co_pipe = 1'b0;

        // Count clamping while parked in INIT.
        wr_psum_in = 1'b1; tick();
        co_psum = 1'b1; tick();
        co_psum = 1'b0; num_filters = 3'd0; tick();
        chk("clamp0", 32'(psum_mult), 32'd1);
        num_filters = 3'd7; tick();
        chk("clamp7", 32'(psum_mult), 32'd4);

        // Reset asserted while in WRITE.
        wr_psum_in = 1'b0; tick();
        tick();
        at_end_data = 1'b1; num_filters = 3'd2; tick();
        at_end_data = 1'b0; wr_psum_in = 1'b1; tick();
        tick();
        chk("write_done", 32'(last_obs[B_DN]), 32'd1);
        rst = 1'b1; tick();
        chk("rst_write", 32'(obs[20:5]), 32'd0);
        chk("rst_write_mult", 32'(psum_mult), 32'd1);
        rst = 1'b0; wr_psum_in = 1'b0;

        // Randomized traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            rst              = ($urandom_range(0, 99) == 0);
            Start            = $urandom_range(0, 1) != 0;
            num_filters      = 3'($urandom_range(0, 7));
            wait_data        = ($urandom_range(0, 3) == 0);
            at_end_data      = ($urandom_range(0, 9) == 0);
            co_pipe          = $urandom_range(0, 1) != 0;
            valid_start_addr = $urandom_range(0, 1) != 0;
            wr_psum_in       = $urandom_range(0, 1) != 0;
            co_psum          = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_filter_control_unit.md
# multi_filter_control_unit

Main controller for the convolution datapath, generalised from fixed 1/2-filter modes to a runtime-selectable count of 1..MAX_FILTERS filters sharing one input-feature (IF) window. It sequences parameter load, IF fetch, pipelined MAC runs with per-filter interleaving, and partial-sum (psum) write-back. It sits between the top-level start/done handshake and the IF/filter/psum scratchpads and pipeline.

## Interface
Parameters:
- MAX_FILTERS, 4: largest filter count interleaved per IF window (≥2).
- FI_W, $clog2(MAX_FILTERS): filter-index width.
- NF_W, $clog2(MAX_FILTERS+1): width of the filter-count input.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  start pulse/level from host.
- num_filters  in  NF_W  filters per IF window; sampled in INIT; 0 and values >MAX_FILTERS clamp to 1 and MAX_FILTERS.
- wait_data, at_end_data, co_pipe, valid_start_addr, wr_psum_in, co_psum  in  1 each  datapath status (same meaning as current datapath).
- run_pipe, read_data, read_filter, clr_pipe, done_data, clr_addr, wen_Psum  out  1 each  pipeline/scratchpad strobes.
- ld_params, r_next_IF, r_next_Filter, ld_psum_addr, sel_psum_addr, clr_psum_addr, done_psum  out  1 each  setup/write-back strobes.
- filter_idx  out  FI_W  filter slot currently fed to the pipe (replaces second_filter).
- psum_mult  out  NF_W  latched filter count; psum address stride multiplier (replaces double_count_psum).
- ready, done  out  1 each  host handshake.

## Operation
- Registers: ps (state), nf_q (clamped count, reset 1), fidx (reset 0). Outputs decoded combinationally from ps and inputs; all outputs 0 in IDLE and after reset; psum_mult = nf_q, filter_idx = fidx.
- IDLE: Start→WAIT_START.
- WAIT_START: stay while Start; on Start low→INIT.
- INIT: ld_params=ready=1; nf_q←clamp(num_filters); fidx←0. If wr_psum_in stay; else assert r_next_IF, r_next_Filter, and ld_psum_addr=sel_psum_addr=(clamped count>1); →READ_NEW_DATA.
- READ_NEW_DATA: no strobes; fidx←0; stay while wait_data, else→RUN.
- RUN, priority: at_end_data→WAIT_WR; else (!valid_start_addr & wait_data)→READ_NEW_DATA; else stay.
- RUN strobes: wen_Psum=run_pipe=read_filter=!wait_data; read_data=!wait_data & (fidx==0) (IF word fetched once, reused by all filters); done_data=clr_addr=at_end_data; r_next_IF=at_end_data & (nf_q==1); clr_pipe=co_pipe & !wait_data.
- fidx in RUN: when !wait_data, fidx←(fidx==nf_q-1)?0:fidx+1; held while wait_data; cleared on leaving RUN.
- WAIT_WR: clr_psum_addr=wr_psum_in; wr_psum_in→WRITE.
- WRITE: done_psum=done=1, ld_psum_addr=co_psum; co_psum→INIT.

## Timing
- State update on posedge clk; strobes are same-cycle (Mealy) on inputs.
- Start-to-INIT: Start deassert + 1 cycle. INIT→RUN ≥2 cycles.
- nf_q==1: filter_idx constant 0, read_data every non-stalled RUN cycle (equal to old mode 1/3 rate).
- nf_q==N: one IF read per N advancing RUN cycles.
- at_end_data with co_pipe same cycle: clr_pipe and done_data both fire, exit to WAIT_WR.
- rst mid-operation: next edge ps=IDLE, fidx=0, nf_q=1; all strobes 0 that cycle onward.
- num_filters changes outside INIT have no effect.

## Configuration
- MFCU_STALL_CNT_EN: when defined, adds output stall_cycles [31:0], counting cycles in READ_NEW_DATA plus RUN cycles with wait_data=1; cleared in INIT, saturates at all-ones, reset 0. When undefined, port and counter absent; behaviour otherwise identical.

## Structure
- Shared package: state encoding constants (IDLE, WAIT_START, INIT, READ_NEW_DATA, RUN, WAIT_WR, WRITE; 3-bit) and a clamp function for num_filters.
- One sub-module natural: mfcu_filter_counter (fidx wrap counter with enable/clear/limit), reused by psum address generator.

## Test plan
- Reset held 3 cycles with Start=1 → ps=IDLE, all outputs 0, psum_mult=1.
- num_filters=1, no stalls, 8-beat window → read_data high 8 consecutive cycles, filter_idx=0, r_next_IF with at_end_data, then WAIT_WR.
- num_filters=3, no stalls → filter_idx 0,1,2,0,1,2…; read_data only when filter_idx=0; ld_psum_addr/sel_psum_addr high in INIT.
- num_filters=3, wait_data=1 with valid_start_addr=1 at fidx=1 → fidx held at 1, run_pipe=0; with valid_start_addr=0 → READ_NEW_DATA, fidx returns 0.
- num_filters=0 and 7 (MAX_FILTERS=4) → psum_mult 1 and 4 respectively.
- WAIT_WR with wr_psum_in=1, co_psum on 4th WRITE cycle → clr_psum_addr 1 cycle, done 4 cycles, ld_psum_addr on last, back to INIT; rst asserted in WRITE → IDLE next edge.
